// File: rtl/display_ctrl.sv
// Display source scheduler for the stopwatch's 4-digit seven-segment display.
// Chooses between the live stopwatch value, a held lap capture, and the value
// being edited in adjust mode. The edited field blinks. Every output is a
// register loaded from next-state values, so a transition is visible on the
// same edge that samples its cause.
module display_ctrl #(
   parameter int HOLD_TICKS = 1000,  // cycles a lap value stays on the display
   parameter int BLINK_HALF = 250    // half-period of the adjust blink
) (
   input  logic       clk_500Hz,
   input  logic       rst,
   input  logic [5:0] run_min,
   input  logic [5:0] run_sec,
   input  logic       lap_req,
   input  logic       adj_mode,
   input  logic       adj_sel,
   input  logic [5:0] adj_min,
   input  logic [5:0] adj_sec,
   output logic [5:0] disp_min,
   output logic [5:0] disp_sec,
   output logic [3:0] disp_blank,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      LAP    = 2'b01,
      ADJUST = 2'b10
   } state_t;

   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   state_t        state, state_nx;
   logic [5:0]    lap_min, lap_min_nx;
   logic [5:0]    lap_sec, lap_sec_nx;
   logic [HW-1:0] hold_cnt, hold_nx;
   logic [BW-1:0] blink_cnt, blink_cnt_nx;
   logic          blink_ph, blink_ph_nx;
   logic          sel_q;
   logic [5:0]    src_min, src_sec;
   logic [3:0]    blank_nx;

   // Values above 59 cannot be shown as minutes/seconds; saturate them.
   function automatic logic [5:0] clamp59(input logic [5:0] v);
      return (v > 6'd59) ? 6'd59 : v;
   endfunction

   // Next-state, lap capture, counters and next output values.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can leave
      // one unassigned, which would otherwise infer a latch.
      state_nx     = state;
      lap_min_nx   = lap_min;
      lap_sec_nx   = lap_sec;
      hold_nx      = '0;
      blink_cnt_nx = '0;
      blink_ph_nx  = 1'b0;
      src_min      = run_min;
      src_sec      = run_sec;
      blank_nx     = 4'b0000;

      unique case (state)
         RUN: begin
            if (adj_mode) begin
               state_nx = ADJUST;
            end else if (lap_req) begin
               state_nx   = LAP;
               lap_min_nx = run_min;
               lap_sec_nx = run_sec;
               hold_nx    = HOLD_LAST;
            end
         end
         LAP: begin
            if (adj_mode) begin
               state_nx = ADJUST;
            end else if (lap_req) begin
               lap_min_nx = run_min;
               lap_sec_nx = run_sec;
               hold_nx    = HOLD_LAST;
            end else if (hold_cnt == '0) begin
               state_nx = RUN;
            end else begin
               hold_nx = hold_cnt - 1'b1;
            end
         end
         ADJUST: begin
            if (!adj_mode) state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase

      // Output source follows the state being entered.
      unique case (state_nx)
         LAP: begin
            src_min = lap_min_nx;
            src_sec = lap_sec_nx;
         end
         ADJUST: begin
            src_min = adj_min;
            src_sec = adj_sec;
            // Entry and a field change both restart the visible half-period.
            if (state == ADJUST && adj_sel == sel_q) begin
               if (blink_cnt == BLINK_LAST) begin
                  blink_cnt_nx = '0;
                  blink_ph_nx  = ~blink_ph;
               end else begin
                  blink_cnt_nx = blink_cnt + 1'b1;
                  blink_ph_nx  = blink_ph;
               end
            end
            if (blink_ph_nx) blank_nx = adj_sel ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   // State, counters and registered outputs; synchronous reset wins over all.
   always_ff @(posedge clk_500Hz) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state      <= RUN;
         lap_min    <= '0;
         lap_sec    <= '0;
         hold_cnt   <= '0;
         blink_cnt  <= '0;
         blink_ph   <= 1'b0;
         sel_q      <= 1'b0;
         disp_min   <= '0;
         disp_sec   <= '0;
         disp_blank <= 4'b0000;
      end else begin
         state      <= state_nx;
         lap_min    <= lap_min_nx;
         lap_sec    <= lap_sec_nx;
         hold_cnt   <= hold_nx;
         blink_cnt  <= blink_cnt_nx;
         blink_ph   <= blink_ph_nx;
         sel_q      <= adj_sel;
         disp_min   <= clamp59(src_min);
         disp_sec   <= clamp59(src_sec);
         disp_blank <= blank_nx;
      end
   end

   assign mode = state;

endmodule

// File: tb/tb_display_ctrl.sv
// Directed bench for display_ctrl with short hold/blink periods. Each applied
// vector pushes its expected outputs, tagged with the cycle they should appear
// in, onto a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_display_ctrl;

   localparam int HOLD = 4;
   localparam int HALF = 3;

   logic       clk_500Hz = 1'b0;
   logic       rst;
   logic [5:0] run_min, run_sec, adj_min, adj_sec;
   logic       lap_req, adj_mode, adj_sel;
   logic [5:0] disp_min, disp_sec;
   logic [3:0] disp_blank;
   logic [1:0] mode;

   typedef struct {
      int         cyc;
      string      name;
      logic [5:0] emin;
      logic [5:0] esec;
      logic [3:0] eblank;
      logic [1:0] emode;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   display_ctrl #(.HOLD_TICKS(HOLD), .BLINK_HALF(HALF)) dut (
      .clk_500Hz (clk_500Hz),
      .rst       (rst),
      .run_min   (run_min),
      .run_sec   (run_sec),
      .lap_req   (lap_req),
      .adj_mode  (adj_mode),
      .adj_sel   (adj_sel),
      .adj_min   (adj_min),
      .adj_sec   (adj_sec),
      .disp_min  (disp_min),
      .disp_sec  (disp_sec),
      .disp_blank(disp_blank),
      .mode      (mode)
   );

   always #5 clk_500Hz = ~clk_500Hz;

   always @(posedge clk_500Hz) cyc <= cyc + 1;

   // Monitor: compare every entry due in the cycle that just completed.
   always @(negedge clk_500Hz) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         vectors++;
         if (e.cyc < cyc) begin
            miscompares++;
            $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
         end else if (disp_min !== e.emin || disp_sec !== e.esec ||
                      disp_blank !== e.eblank || mode !== e.emode) begin
            miscompares++;
            $display("FAIL %s @%0d: got %0d:%0d blank=%b mode=%b, want %0d:%0d blank=%b mode=%b",
                     e.name, cyc, disp_min, disp_sec, disp_blank, mode,
                     e.emin, e.esec, e.eblank, e.emode);
         end
      end
   end

   // Drive one cycle of inputs (called just after a rising edge) and record the
   // outputs expected after the next rising edge.
   task automatic v(input string name, input logic r,
                    input int rm, input int rs, input logic lap,
                    input logic adj, input logic sel, input int am, input int as_,
                    input int em, input int es, input logic [3:0] eb, input logic [1:0] emd);
      exp_t e;
      rst = r; run_min = 6'(rm); run_sec = 6'(rs); lap_req = lap;
      adj_mode = adj; adj_sel = sel; adj_min = 6'(am); adj_sec = 6'(as_);
      e.cyc = cyc + 1; e.name = name;
      e.emin = 6'(em); e.esec = 6'(es); e.eblank = eb; e.emode = emd;
      sb.push_back(e);
      @(posedge clk_500Hz);
      #1;
   endtask

   initial begin
      rst = 1'b1; run_min = '0; run_sec = '0; lap_req = 1'b0;
      adj_mode = 1'b0; adj_sel = 1'b0; adj_min = '0; adj_sec = '0;
      @(posedge clk_500Hz);
      #1;

      // 1: reset and live display
      v("rst",      1, 12,34, 0, 0,0, 0,0,   0, 0, 4'b0000, 2'b00);
      v("run0",     0, 12,34, 0, 0,0, 0,0,  12,34, 4'b0000, 2'b00);
      v("run1",     0, 12,34, 0, 0,0, 0,0,  12,34, 4'b0000, 2'b00);

      // 2: lap hold of exactly HOLD cycles
      v("lap_cap",  0,  1, 5, 1, 0,0, 0,0,   1, 5, 4'b0000, 2'b01);
      v("lap_h1",   0,  1, 9, 0, 0,0, 0,0,   1, 5, 4'b0000, 2'b01);
      v("lap_h2",   0,  1, 9, 0, 0,0, 0,0,   1, 5, 4'b0000, 2'b01);
      v("lap_h3",   0,  1, 9, 0, 0,0, 0,0,   1, 5, 4'b0000, 2'b01);
      v("lap_end",  0,  1, 9, 0, 0,0, 0,0,   1, 9, 4'b0000, 2'b00);
      v("lap_run",  0,  1, 9, 0, 0,0, 0,0,   1, 9, 4'b0000, 2'b00);
      // second lap_req recaptures and restarts the hold
      v("rl_cap",   0,  1, 5, 1, 0,0, 0,0,   1, 5, 4'b0000, 2'b01);
      v("rl_h1",    0,  2, 7, 0, 0,0, 0,0,   1, 5, 4'b0000, 2'b01);
      v("rl_recap", 0,  2, 7, 1, 0,0, 0,0,   2, 7, 4'b0000, 2'b01);
      v("rl_h2",    0,  3, 0, 0, 0,0, 0,0,   2, 7, 4'b0000, 2'b01);
      v("rl_h3",    0,  3, 0, 0, 0,0, 0,0,   2, 7, 4'b0000, 2'b01);
      v("rl_h4",    0,  3, 0, 0, 0,0, 0,0,   2, 7, 4'b0000, 2'b01);
      v("rl_end",   0,  3, 0, 0, 0,0, 0,0,   3, 0, 4'b0000, 2'b00);
      // reset in the middle of a lap
      v("rm_cap",   0,  1, 5, 1, 0,0, 0,0,   1, 5, 4'b0000, 2'b01);
      v("rm_rst",   1,  1, 5, 0, 0,0, 0,0,   0, 0, 4'b0000, 2'b00);
      v("rm_run",   0,  1, 5, 0, 0,0, 0,0,   1, 5, 4'b0000, 2'b00);

      // 3: adjust blink on minutes, then switch to seconds
      v("adj_in",   0,  1, 5, 0, 1,0, 7,45,  7,45, 4'b0000, 2'b10);
      v("adj_v1",   0,  1, 5, 0, 1,0, 7,45,  7,45, 4'b0000, 2'b10);
      v("adj_v2",   0,  1, 5, 0, 1,0, 7,45,  7,45, 4'b0000, 2'b10);
      v("adj_d0",   0,  1, 5, 0, 1,0, 7,45,  7,45, 4'b0011, 2'b10);
      v("adj_d1",   0,  1, 5, 0, 1,0, 7,45,  7,45, 4'b0011, 2'b10);
      v("adj_d2",   0,  1, 5, 0, 1,0, 7,45,  7,45, 4'b0011, 2'b10);
      v("adj_v3",   0,  1, 5, 0, 1,0, 7,45,  7,45, 4'b0000, 2'b10);
      v("adj_v4",   0,  1, 5, 0, 1,0, 7,45,  7,45, 4'b0000, 2'b10);
      v("sel_sw",   0,  1, 5, 0, 1,1, 7,45,  7,45, 4'b0000, 2'b10);
      v("sel_v1",   0,  1, 5, 0, 1,1, 7,45,  7,45, 4'b0000, 2'b10);
      v("sel_v2",   0,  1, 5, 0, 1,1, 7,45,  7,45, 4'b0000, 2'b10);
      v("sel_d0",   0,  1, 5, 0, 1,1, 7,45,  7,45, 4'b1100, 2'b10);
      v("sel_d1",   0,  1, 5, 0, 1,1, 7,45,  7,45, 4'b1100, 2'b10);
      v("adj_lap",  0,  1, 5, 1, 1,1, 7,45,  7,45, 4'b1100, 2'b10);
      v("adj_wrap", 0,  1, 5, 0, 1,1, 7,45,  7,45, 4'b0000, 2'b10);
      v("adj_out",  0,  1, 5, 0, 0,1, 7,45,  1, 5, 4'b0000, 2'b00);

      // 4: priority
      v("pa_cap",   0,  1, 5, 1, 0,0, 7,45,  1, 5, 4'b0000, 2'b01);
      v("pa_adj",   0,  1, 5, 0, 1,0, 7,45,  7,45, 4'b0000, 2'b10);
      v("pa_exit",  0,  2, 0, 0, 0,0, 7,45,  2, 0, 4'b0000, 2'b00);
      v("pa_run",   0,  2, 0, 0, 0,0, 7,45,  2, 0, 4'b0000, 2'b00);
      v("pb_both",  0,  2, 0, 1, 1,0, 7,45,  7,45, 4'b0000, 2'b10);
      v("pb_exit",  0,  2, 1, 0, 0,0, 7,45,  2, 1, 4'b0000, 2'b00);
      v("pb_run",   0,  2, 2, 0, 0,0, 7,45,  2, 2, 4'b0000, 2'b00);

      // 5: clamping of live, lap and adjust values
      v("cl_run",   0, 60,63, 0, 0,0, 0,0,  59,59, 4'b0000, 2'b00);
      v("cl_lap",   0, 60,63, 1, 0,0, 0,0,  59,59, 4'b0000, 2'b01);
      v("cl_h1",    0,  0, 0, 0, 0,0, 0,0,  59,59, 4'b0000, 2'b01);
      v("cl_h2",    0,  0, 0, 0, 0,0, 0,0,  59,59, 4'b0000, 2'b01);
      v("cl_h3",    0,  0, 0, 0, 0,0, 0,0,  59,59, 4'b0000, 2'b01);
      v("cl_end",   0,  0, 0, 0, 0,0, 0,0,   0, 0, 4'b0000, 2'b00);
      v("cl_adj",   0,  0, 0, 0, 1,0, 5,62,  5,59, 4'b0000, 2'b10);
      v("cl_adj2",  0,  0, 0, 0, 1,0, 63,9, 59, 9, 4'b0000, 2'b10);

      // Let the monitor drain the scoreboard, with a bounded wait.
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_500Hz);
      if (sb.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries never compared, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/display_ctrl.md
# display_ctrl

Display source scheduler for the stopwatch's 4-digit seven-segment display. It chooses which minutes/seconds pair is shown: the live stopwatch value, a captured lap value held for a fixed time, or the value being edited in adjust mode. In adjust mode the field being edited blinks. It sits between the timekeeping/adjust logic and the digit multiplexer, and all of its outputs are registered.

## Interface
- HOLD_TICKS, 1000: number of clk_500Hz cycles a lap value stays on the display (2 s).
- BLINK_HALF, 250: half-period of the adjust blink, in cycles (1 Hz blink).
- clk_500Hz  input  1  display/scheduler clock.
- rst  input  1  reset: synchronous, active-high.
- run_min  input  6  live stopwatch minutes.
- run_sec  input  6  live stopwatch seconds.
- lap_req  input  1  single-cycle pulse; captures run_min/run_sec and shows them.
- adj_mode  input  1  level; high while the user is adjusting time.
- adj_sel  input  1  field being edited: 0 = minutes, 1 = seconds.
- adj_min  input  6  minutes value being edited.
- adj_sec  input  6  seconds value being edited.
- disp_min  output  6  minutes value sent to the digit multiplexer.
- disp_sec  output  6  seconds value sent to the digit multiplexer.
- disp_blank  output  4  per-digit blank, 1 = digit dark. Bit order: [0] min tens, [1] min ones, [2] sec tens, [3] sec ones.
- mode  output  2  current state: 00 RUN, 01 LAP, 10 ADJUST.

## Operation
- Three states: RUN, LAP, ADJUST. Priority order: adj_mode, then lap hold, then run.
- **RUN**
  - Shows run_min/run_sec; disp_blank = 0000.
  - lap_req=1 → LAP.
  - adj_mode=1 → ADJUST. This wins if lap_req and adj_mode are high in the same cycle.
- **LAP**
  - Shows lap_min/lap_reg registers (captured copy of run_min/run_sec); disp_blank = 0000.
  - hold_cnt counts down from HOLD_TICKS-1. At 0 → RUN.
  - lap_req=1 again: recapture the run values and reload hold_cnt.
  - adj_mode=1: abort the lap and go to ADJUST. The lap is not resumed afterwards.
- **ADJUST**
  - Shows adj_min/adj_sec.
  - Entry clears blink_cnt and blink_ph.
  - blink_cnt counts 0..BLINK_HALF-1. On wrap it returns to 0 and blink_ph toggles.
  - blink_ph=1 blanks the selected pair: adj_sel=0 → disp_blank=0011; adj_sel=1 → disp_blank=1100. blink_ph=0 → disp_blank=0000.
  - Any change of adj_sel clears blink_cnt and blink_ph, so the newly selected field shows immediately.
  - lap_req is ignored.
  - adj_mode=0 → RUN.
- **Range rule:** any displayed minutes/seconds value above 59 is clamped to 59 before it is registered. Lap capture stores the raw (unclamped) value.

## Timing
- Reset values:
  - mode=00, disp_min=0, disp_sec=0, disp_blank=0000.
  - lap registers = 0, hold_cnt = 0, blink_cnt = 0, blink_ph = 0.
  - rst overrides all other inputs, including in the middle of a lap or an adjust.
- Output registers load from next-state values. On the edge that samples a transition condition, the outputs already reflect the new state. Latency from input to output is 1 cycle.
- LAP duration: the lap value is shown for exactly HOLD_TICKS cycles after the lap_req edge. On the following edge, run values are shown.
- Blink: after ADJUST entry, the selected field is visible for BLINK_HALF cycles, then dark for BLINK_HALF cycles, repeating.
- In RUN and ADJUST, disp_min/disp_sec follow their input values with 1-cycle delay, every cycle.
- Counters never wrap outside their stated ranges. hold_cnt is idle (0) outside LAP.

## Test plan
1. Reset, then hold run_min=12, run_sec=34 → from the next edge disp=12:34, blank=0000, mode=00. Assert rst in the middle of a lap → the next edge shows 0:0 and mode=00.
2. Lap with HOLD_TICKS=4, run=01:05: pulse lap_req, then change run to 01:09 → disp=01:05 for exactly 4 cycles, then 01:09, mode 01→00. A second lap_req at cycle 2 recaptures and the 4-cycle hold restarts.
3. Adjust with BLINK_HALF=3, adj_sel=0, adj=07:45: raise adj_mode → disp=07:45, blank 0000 for 3 cycles, 0011 for 3, repeating. Switch adj_sel to 1 → blank=0000 on the next edge, then 1100 after 3 cycles.
4. Priority cases:
   - adj_mode rises during LAP → next edge mode=10 and adj values shown; dropping adj_mode returns to RUN, not LAP.
   - lap_req and adj_mode high together in RUN → ADJUST.
   - lap_req during ADJUST → no effect.
5. Clamp: run_sec=63, run_min=60 → disp=59:59. A lap captured during that input shows 59:59. Feeding adj_sec=62 in ADJUST → disp_sec=59.
